// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and the result flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
    logic carry;
    logic err;
  } alu_flags_t;

  // Highest legal opcode; anything above it is reported through the err flag.
  localparam int unsigned ALU_OP_LAST = 9;

  localparam int unsigned ALU_FLAGS_W = $bits(alu_flags_t);

endpackage

// File: rtl/alu_pipe_stage.sv
// One elastic valid/ready register slice. The payload is held untouched while
// the downstream side stalls, and the slice refills in the same cycle it drains.
module alu_pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // Accept when empty or when the current entry leaves this cycle.
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  // Slice state; reset clears the payload too so outputs read zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: the operation is evaluated at acceptance and the result,
// flags and tag then travel through a chain of elastic register slices.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic [TAG_W-1:0] tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             carry,
  output logic             err,
  output logic             busy
);

  localparam int SH_W = $clog2(WIDTH);
  localparam int MSB  = WIDTH - 1;
  localparam int DW   = WIDTH + ALU_FLAGS_W + TAG_W;

  alu_op_e          op_e;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] alu_res;
  alu_flags_t       alu_flags;

  assign op_e  = alu_op_e'(op);
  assign shamt = b[SH_W-1:0];

  // Operation and flag evaluation on the request operands.
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    sum_w     = {1'b0, a} + {1'b0, b};
    diff_w    = {1'b0, a} - {1'b0, b};
    case (op_e)
      ALU_ADD: begin
        alu_res         = sum_w[WIDTH-1:0];
        alu_flags.carry = sum_w[WIDTH];
        alu_flags.ovf   = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        alu_res         = diff_w[WIDTH-1:0];
        alu_flags.carry = !diff_w[WIDTH];
        alu_flags.ovf   = (a[MSB] != b[MSB]) && (diff_w[MSB] != a[MSB]);
      end
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  alu_res = a << shamt;
      ALU_SRL:  alu_res = a >> shamt;
      ALU_SRA:  alu_res = $signed(a) >>> shamt;
      default:  alu_res = '0;
    endcase
    if (op > 4'(ALU_OP_LAST)) begin
      alu_res       = '0;
      alu_flags.err = 1'b1;
    end
    alu_flags.zero = (alu_res == '0);
    alu_flags.neg  = alu_res[MSB];
  end

  logic          stg_valid [0:STAGES];
  logic          stg_ready [0:STAGES];
  logic [DW-1:0] stg_data  [0:STAGES];
  logic [STAGES-1:0] occupied;

  assign stg_valid[0]      = req_valid;
  assign stg_data[0]       = {alu_res, alu_flags, tag};
  assign stg_ready[STAGES] = rsp_ready;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      alu_pipe_stage #(.DW(DW)) u_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (stg_valid[gi]),
        .in_ready  (stg_ready[gi]),
        .in_data   (stg_data[gi]),
        .out_valid (stg_valid[gi+1]),
        .out_ready (stg_ready[gi+1]),
        .out_data  (stg_data[gi+1])
      );
      assign occupied[gi] = stg_valid[gi+1];
    end
  endgenerate

  alu_flags_t rsp_flags;

  assign req_ready = stg_ready[0];
  assign rsp_valid = stg_valid[STAGES];
  assign {result, rsp_flags, rsp_tag} = stg_data[STAGES];
  assign zero  = rsp_flags.zero;
  assign neg   = rsp_flags.neg;
  assign ovf   = rsp_flags.ovf;
  assign carry = rsp_flags.carry;
  assign err   = rsp_flags.err;
  assign busy  = |occupied;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=32, STAGES=2, TAG_W=4): directed vectors plus a
// randomized run, scored against an arithmetic reference model and a queue.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  op = '0;
  logic [3:0]  tag = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] result;
  logic [3:0]  rsp_tag;
  logic        zero, neg, ovf, carry, err, busy;

  alu_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .tag       (tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .result    (result),
    .rsp_tag   (rsp_tag),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf),
    .carry     (carry),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flags;   // {zero, neg, ovf, carry, err}
    logic [3:0]  tag;
  } exp_t;

  int checks = 0;
  int failures = 0;
  exp_t expq[$];
  logic [3:0] tag_log[$];
  logic        hold_pending = 1'b0;
  logic [31:0] held_res;
  logic [4:0]  held_flags;
  logic [3:0]  held_tag;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
    end
  endtask

  // Reference behaviour from plain arithmetic on integers.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic [3:0] o, input logic [3:0] t);
    exp_t   e;
    longint sx, sy, s;
    logic   v, c, er;
    logic [31:0] r;
    logic [4:0]  sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = y[4:0];
    v = 1'b0; c = 1'b0; er = 1'b0; r = '0;
    case (o)
      4'd0: begin
        r = x + y;
        c = (longint'({32'b0, x}) + longint'({32'b0, y})) > 64'hFFFF_FFFF;
        s = sx + sy;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        r = x - y;
        c = (x >= y);
        s = sx - sy;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = x ^ y;
      4'd5: r = (sx < sy) ? 32'd1 : 32'd0;
      4'd6: r = (x < y) ? 32'd1 : 32'd0;
      4'd7: r = x << sh;
      4'd8: r = x >> sh;
      4'd9: r = 32'($signed(x) >>> sh);
      default: begin r = '0; er = 1'b1; end
    endcase
    e.res   = r;
    e.flags = {(r == 32'd0), r[31], v, c, er};
    e.tag   = t;
    return e;
  endfunction

  // One clock cycle: drive, settle, score both handshakes, then cross the edge.
  task automatic step(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                      input logic [3:0] iop, input logic [3:0] itag, input logic rr,
                      output logic acc);
    exp_t e;
    req_valid = v; a = ia; b = ib; op = iop; tag = itag; rsp_ready = rr;
    #1;
    if (hold_pending) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", result, held_res);
      chk("hold_flags", {zero, neg, ovf, carry, err}, held_flags);
      chk("hold_tag", rsp_tag, held_tag);
    end
    if (rsp_valid && rsp_ready) begin
      if (expq.size() == 0) begin
        chk("spurious_rsp", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("rsp_result", result, e.res);
        chk("rsp_flags", {zero, neg, ovf, carry, err}, e.flags);
        chk("rsp_tag", rsp_tag, e.tag);
        tag_log.push_back(rsp_tag);
      end
    end
    hold_pending = rsp_valid && !rsp_ready;
    held_res = result;
    held_flags = {zero, neg, ovf, carry, err};
    held_tag = rsp_tag;
    acc = req_valid && req_ready;
    if (acc) expq.push_back(model(ia, ib, iop, itag));
    @(posedge clk);
    #1;
  endtask

  // Single request with rsp_ready high: latency and fixed expected values.
  task automatic run_one(input string name, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [3:0] t,
                         input logic [31:0] er, input logic [4:0] ef);
    logic acc;
    step(1'b1, x, y, o, t, 1'b1, acc);
    chk({name, "_accept"}, acc, 1);
    chk({name, "_early"}, rsp_valid, 0);
    step(1'b0, '0, '0, '0, '0, 1'b1, acc);
    chk({name, "_valid"}, rsp_valid, 1);
    chk({name, "_result"}, result, er);
    chk({name, "_flags"}, {zero, neg, ovf, carry, err}, ef);
    chk({name, "_tag"}, rsp_tag, t);
    step(1'b0, '0, '0, '0, '0, 1'b1, acc);
  endtask

  initial begin
    logic        acc;
    int          next_tag;
    int          accepted;
    logic        pv;
    logic [31:0] pa, pb;
    logic [3:0]  pop, ptag;
    int          guard;

    // Reset state
    #3;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_result", result, 0);
    chk("rst_tag", rsp_tag, 0);
    chk("rst_flags", {zero, neg, ovf, carry, err}, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed operation vectors
    run_one("add_ovf",  4'd0, 32'h7FFF_FFFF, 32'd1, 4'd3, 32'h8000_0000, 5'b01100);
    run_one("add_cy",   4'd0, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'h0000_0000, 5'b10010);
    run_one("sub_brw",  4'd1, 32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF, 5'b01000);
    run_one("sub_ok",   4'd1, 32'd5, 32'd3, 4'd2, 32'd2, 5'b00010);
    run_one("slt",      4'd5, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd1, 5'b00000);
    run_one("sltu",     4'd6, 32'hFFFF_FFFF, 32'd1, 4'd6, 32'd0, 5'b10000);
    run_one("sra",      4'd9, 32'h8000_0000, 32'h24, 4'd7, 32'hF800_0000, 5'b01000);
    run_one("sll",      4'd7, 32'd1, 32'd31, 4'd8, 32'h8000_0000, 5'b01000);
    run_one("illegal",  4'd12, 32'h1234, 32'h5678, 4'd9, 32'd0, 5'b10001);
    run_one("after_ill",4'd0, 32'd1, 32'd1, 4'd10, 32'd2, 5'b00000);

    // Backpressure: fill, stall, then drain in order
    tag_log.delete();
    next_tag = 0;
    accepted = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(next_tag), 32'(next_tag + 10), 4'd0, 4'(next_tag), 1'b0, acc);
      if (acc) begin next_tag++; accepted++; end
    end
    chk("bp_accepts", accepted, 2);
    chk("bp_req_ready", req_ready, 0);
    chk("bp_busy", busy, 1);
    chk("bp_head_tag", rsp_tag, 0);
    for (int i = 0; i < 4; i++) begin
      if (next_tag < 4) begin
        step(1'b1, 32'(next_tag), 32'(next_tag + 10), 4'd0, 4'(next_tag), 1'b1, acc);
        if (i == 0) chk("full_accept_on_consume", acc, 1);
        if (acc) next_tag++;
      end else begin
        step(1'b0, '0, '0, '0, '0, 1'b1, acc);
      end
    end
    chk("bp_drain_count", tag_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < tag_log.size()) chk("bp_order", tag_log[i], 4'(i));
    end
    chk("bp_empty_busy", busy, 0);

    // Reset while full and stalled
    step(1'b1, 32'd7, 32'd8, 4'd0, 4'd1, 1'b0, acc);
    step(1'b1, 32'd9, 32'd1, 4'd1, 4'd2, 1'b0, acc);
    step(1'b0, '0, '0, '0, '0, 1'b0, acc);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_result", result, 0);
    expq.delete();
    hold_pending = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_one("post_rst_add", 4'd0, 32'd2, 32'd3, 4'd11, 32'd5, 5'b00000);

    // Randomized traffic with random backpressure
    pv = 1'b0; pa = '0; pb = '0; pop = '0; ptag = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pv && ($urandom_range(0, 9) < 7)) begin
        pv = 1'b1;
        case ($urandom_range(0, 3))
          0: pa = 32'h7FFF_FFFF;
          1: pa = 32'h8000_0000;
          default: pa = $urandom;
        endcase
        case ($urandom_range(0, 3))
          0: pb = 32'hFFFF_FFFF;
          1: pb = $urandom_range(0, 40);
          default: pb = $urandom;
        endcase
        pop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        ptag = ptag + 4'd1;
      end
      step(pv, pa, pb, pop, ptag, ($urandom_range(0, 9) < 6), acc);
      if (acc) pv = 1'b0;
    end
    guard = 0;
    while ((expq.size() != 0) && (guard < 64)) begin
      step(1'b0, '0, '0, '0, '0, 1'b1, acc);
      guard++;
    end
    chk("final_drain", expq.size(), 0);
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits; legal range 8..64.
REQ-002 Parameter STAGES, default 2: pipeline depth in register stages; legal range 1..8.
REQ-003 Parameter TAG_W, default 4: width of the request tag carried through to the response.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block can accept the request this cycle.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 op  input  4  operation, typed as alu_op_e.
REQ-010 tag  input  TAG_W  opaque request identifier.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  consumer accepts the response.
REQ-013 result  output  WIDTH  operation result.
REQ-014 rsp_tag  output  TAG_W  tag of the request that produced this response.
REQ-015 zero, neg, ovf, carry, err  output  1 each  result flags.
REQ-016 busy  output  1  asserted while any stage holds a valid entry.

Function
REQ-017 A request transfers when req_valid && req_ready; a response transfers when rsp_valid && rsp_ready.
REQ-018 Elastic pipeline: stage i advances when it is empty or stage i+1 can accept; last stage advances on rsp_ready; req_ready = stage 0 empty or stage 0 advancing.
REQ-019 With rsp_ready held high, rsp_valid rises exactly STAGES cycles after the accepting edge; sustained throughput is one result per cycle.
REQ-020 Under backpressure, the block holds every result, flag and tag stable while rsp_valid && !rsp_ready; no entry is dropped, duplicated or reordered.
REQ-021 When full, the block accepts a new request in the same cycle that the oldest entry is consumed; capacity is STAGES entries.
REQ-022 Operations: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5 (signed), SLTU=6, SLL=7, SRL=8, SRA=9.
REQ-023 Shift amount = b[$clog2(WIDTH)-1:0]; the block ignores the upper bits of b.
REQ-024 ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum; ovf = operand signs equal and result sign differs.
REQ-025 SUB: carry = NOT borrow; ovf = operand signs differ and result sign differs from a.
REQ-026 For all non-ADD/SUB operations, ovf = 0 and carry = 0.
REQ-027 SLT/SLTU: result = {0..., compare bit}.
REQ-028 zero = (result == 0) and neg = result[WIDTH-1] for every operation.
REQ-029 Op codes 10..15: result 0, err 1, zero 1, other flags 0; the entry still flows and occupies a slot. err = 0 for legal codes.
REQ-030 The result is computed combinationally from a/b/op at acceptance and registered into stage 0; later stages only move data.
REQ-031 busy = OR of all stage valid bits.

Reset
REQ-032 Asserting rst_n low clears all stage valid bits immediately, discarding any in-flight entries, including mid-backpressure.
REQ-033 During and after reset: rsp_valid = 0, busy = 0, req_ready = 1, and result, rsp_tag and all flags read 0.
REQ-034 The first accepting edge after rst_n deasserts behaves as in REQ-019.

Structure
REQ-035 alu_pkg holds: alu_op_e (4-bit, REQ-022 encodings), the packed struct alu_flags_t {zero, neg, ovf, carry, err}, and the constant ALU_OP_LAST = 9.
REQ-036 One sub-module, alu_pipe_stage (a parametrised valid/ready register slice carrying result, flags and tag), instantiated STAGES times by a generate loop.

Verification (WIDTH=32, STAGES=2, TAG_W=4)
REQ-037 ADD a=0x7FFFFFFF, b=1, tag=3 -> 2 cycles later: result=0x80000000, ovf=1, carry=0, neg=1, rsp_tag=3.
REQ-038 SUB a=0, b=1 -> result=0xFFFFFFFF, carry=0, ovf=0; SLT a=0xFFFFFFFF, b=1 -> result=1; SLTU with the same operands -> result=0.
REQ-039 SRA a=0x80000000, b=0x24 (shift 4) -> result=0xF8000000; SLL a=1, b=31 -> result=0x80000000, neg=1.
REQ-040 Backpressure: 4 back-to-back requests with tags 0..3 while rsp_ready=0 -> req_ready drops after 2 accepts, busy=1; then raise rsp_ready -> responses arrive in tag order 0,1,2,3, one per cycle, none lost.
REQ-041 op=12 -> result=0, err=1, zero=1; the next legal op that follows has err=0.
REQ-042 Assert rst_n low while the pipeline is full and stalled -> rsp_valid=0 and busy=0 immediately; after release, a new ADD 2+3 -> result=5 after 2 cycles.
